// File: rtl/scr1_tapc_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : scr1_tapc_fsm
//  Description : JTAG TAP controller core for the SCR1 debug path.
//                Runs the 16-state IEEE 1149.1 TAP FSM. Holds the 5-bit IR
//                and the internal IDCODE, BLD_ID and BYPASS data registers.
//                Steers DTMCS, DMI_ACCESS and SCU_ACCESS to external shift
//                chains through a select-plus-strobe interface and drives
//                TDO on the falling edge of TCK.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    tapc_tck      in   1  TCK; rising edge = FSM/IR/DR, falling edge = TDO
//    tapc_trst_n   in   1  TRST, asynchronous, active-low
//    tapc_tms      in   1  TMS, sampled on rising TCK
//    tapc_tdi      in   1  TDI, sampled on rising TCK
//    tapc_tdo      out  1  TDO, registered on falling TCK
//    tapc_tdo_en   out  1  TDO output enable, registered on falling TCK
//    tap_state_o   out  4  current TAP state
//    dr_sel_o      out  3  one-hot external chain: [0]=DTMCS [1]=DMI [2]=SCU
//    dr_capture_o  out  1  external chain capture strobe
//    dr_shift_o    out  1  external chain shift enable
//    dr_update_o   out  1  external chain update strobe
//    dr_tdi_o      out  1  serial data to external chain
//    dr_tdo_i      in   3  serial LSB from each external chain
// ============================================================================
module scr1_tapc_fsm #(
    parameter logic [31:0] IDCODE_VALUE = 32'hDEB11001,
    parameter logic [31:0] BLD_ID_VALUE = 32'h2209_2E01,
    parameter bit          SCU_EN       = 1'b1
) (
    input  logic       tapc_tck,
    input  logic       tapc_trst_n,
    input  logic       tapc_tms,
    input  logic       tapc_tdi,
    output logic       tapc_tdo,
    output logic       tapc_tdo_en,
    output logic [3:0] tap_state_o,
    output logic [2:0] dr_sel_o,
    output logic       dr_capture_o,
    output logic       dr_shift_o,
    output logic       dr_update_o,
    output logic       dr_tdi_o,
    input  logic [2:0] dr_tdo_i
);

    typedef enum logic [3:0] {
        TAP_RESET      = 4'd0,
        TAP_IDLE       = 4'd1,
        TAP_DR_SEL     = 4'd2,
        TAP_DR_CAPTURE = 4'd3,
        TAP_DR_SHIFT   = 4'd4,
        TAP_DR_EXIT1   = 4'd5,
        TAP_DR_PAUSE   = 4'd6,
        TAP_DR_EXIT2   = 4'd7,
        TAP_DR_UPDATE  = 4'd8,
        TAP_IR_SEL     = 4'd9,
        TAP_IR_CAPTURE = 4'd10,
        TAP_IR_SHIFT   = 4'd11,
        TAP_IR_EXIT1   = 4'd12,
        TAP_IR_PAUSE   = 4'd13,
        TAP_IR_EXIT2   = 4'd14,
        TAP_IR_UPDATE  = 4'd15
    } tap_state_e;

    localparam logic [4:0] c_ir_idcode = 5'h01;
    localparam logic [4:0] c_ir_bld_id = 5'h04;
    localparam logic [4:0] c_ir_scu    = 5'h09;
    localparam logic [4:0] c_ir_dtmcs  = 5'h10;
    localparam logic [4:0] c_ir_dmi    = 5'h11;

    tap_state_e  r_state;
    logic [4:0]  r_ir;
    logic [4:0]  r_ir_sreg;
    logic [31:0] r_dr_sreg;
    logic        r_bypass;

    logic [2:0]  w_sel;
    logic        w_is_idcode;
    logic        w_is_bld_id;
    logic        w_is_bypass;
    logic        w_to_reset;
    logic        w_dr_tdo;

    // ------------------------------------------------------------------
    // TAP state machine
    // ------------------------------------------------------------------
    always_ff @(posedge tapc_tck or negedge tapc_trst_n) begin
        if (!tapc_trst_n) begin
            r_state <= TAP_RESET;
        end else begin
            unique case (r_state)
                TAP_RESET:      r_state <= tapc_tms ? TAP_RESET    : TAP_IDLE;
                TAP_IDLE:       r_state <= tapc_tms ? TAP_DR_SEL   : TAP_IDLE;
                TAP_DR_SEL:     r_state <= tapc_tms ? TAP_IR_SEL   : TAP_DR_CAPTURE;
                TAP_DR_CAPTURE: r_state <= tapc_tms ? TAP_DR_EXIT1 : TAP_DR_SHIFT;
                TAP_DR_SHIFT:   r_state <= tapc_tms ? TAP_DR_EXIT1 : TAP_DR_SHIFT;
                TAP_DR_EXIT1:   r_state <= tapc_tms ? TAP_DR_UPDATE: TAP_DR_PAUSE;
                TAP_DR_PAUSE:   r_state <= tapc_tms ? TAP_DR_EXIT2 : TAP_DR_PAUSE;
                TAP_DR_EXIT2:   r_state <= tapc_tms ? TAP_DR_UPDATE: TAP_DR_SHIFT;
                TAP_DR_UPDATE:  r_state <= tapc_tms ? TAP_DR_SEL   : TAP_IDLE;
                TAP_IR_SEL:     r_state <= tapc_tms ? TAP_RESET    : TAP_IR_CAPTURE;
                TAP_IR_CAPTURE: r_state <= tapc_tms ? TAP_IR_EXIT1 : TAP_IR_SHIFT;
                TAP_IR_SHIFT:   r_state <= tapc_tms ? TAP_IR_EXIT1 : TAP_IR_SHIFT;
                TAP_IR_EXIT1:   r_state <= tapc_tms ? TAP_IR_UPDATE: TAP_IR_PAUSE;
                TAP_IR_PAUSE:   r_state <= tapc_tms ? TAP_IR_EXIT2 : TAP_IR_PAUSE;
                TAP_IR_EXIT2:   r_state <= tapc_tms ? TAP_IR_UPDATE: TAP_IR_SHIFT;
                TAP_IR_UPDATE:  r_state <= tapc_tms ? TAP_DR_SEL   : TAP_IDLE;
                default:        r_state <= TAP_RESET;
            endcase
        end
    end

    // Only Test-Logic-Reset itself and Select-IR-Scan lead into RESET, so
    // this is exactly the "about to enter RESET" condition.
    assign w_to_reset = tapc_tms & ((r_state == TAP_RESET) | (r_state == TAP_IR_SEL));

    // ------------------------------------------------------------------
    // Instruction register path
    // ------------------------------------------------------------------
    always_ff @(posedge tapc_tck or negedge tapc_trst_n) begin
        if (!tapc_trst_n) begin
            r_ir_sreg <= 5'd0;
        end else if (r_state == TAP_IR_CAPTURE) begin
            r_ir_sreg <= 5'b00001;
        end else if (r_state == TAP_IR_SHIFT) begin
            r_ir_sreg <= {tapc_tdi, r_ir_sreg[4:1]};
        end
    end

    always_ff @(posedge tapc_tck or negedge tapc_trst_n) begin
        if (!tapc_trst_n) begin
            r_ir <= c_ir_idcode;
        end else if (w_to_reset) begin
            r_ir <= c_ir_idcode;
        end else if (r_state == TAP_IR_UPDATE) begin
            r_ir <= r_ir_sreg;
        end
    end

    // ------------------------------------------------------------------
    // Instruction decode (from the active IR only, never the shift reg)
    // ------------------------------------------------------------------
    always_comb begin
        w_sel       = 3'b000;
        w_is_idcode = 1'b0;
        w_is_bld_id = 1'b0;
        w_is_bypass = 1'b0;
        case (r_ir)
            c_ir_idcode: w_is_idcode = 1'b1;
            c_ir_bld_id: w_is_bld_id = 1'b1;
            c_ir_dtmcs:  w_sel       = 3'b001;
            c_ir_dmi:    w_sel       = 3'b010;
            c_ir_scu: begin
                if (SCU_EN) begin
                    w_sel = 3'b100;
                end else begin
                    w_is_bypass = 1'b1;
                end
            end
            default:     w_is_bypass = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Internal data registers; Update has no effect on them
    // ------------------------------------------------------------------
    always_ff @(posedge tapc_tck or negedge tapc_trst_n) begin
        if (!tapc_trst_n) begin
            r_dr_sreg <= 32'd0;
            r_bypass  <= 1'b0;
        end else if (r_state == TAP_DR_CAPTURE) begin
            r_dr_sreg <= w_is_idcode ? IDCODE_VALUE :
                         w_is_bld_id ? BLD_ID_VALUE : 32'd0;
            r_bypass  <= 1'b0;
        end else if (r_state == TAP_DR_SHIFT) begin
            if (w_is_bypass) begin
                r_bypass <= tapc_tdi;
            end else if (w_is_idcode || w_is_bld_id) begin
                r_dr_sreg <= {tapc_tdi, r_dr_sreg[31:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // TDO, launched on the falling edge so the host samples it on rising
    // ------------------------------------------------------------------
    assign w_dr_tdo = (|w_sel)    ? (|(dr_tdo_i & w_sel)) :
                      w_is_bypass ? r_bypass : r_dr_sreg[0];

    always_ff @(negedge tapc_tck or negedge tapc_trst_n) begin
        if (!tapc_trst_n) begin
            tapc_tdo    <= 1'b0;
            tapc_tdo_en <= 1'b0;
        end else if (r_state == TAP_IR_SHIFT) begin
            tapc_tdo    <= r_ir_sreg[0];
            tapc_tdo_en <= 1'b1;
        end else if (r_state == TAP_DR_SHIFT) begin
            tapc_tdo    <= w_dr_tdo;
            tapc_tdo_en <= 1'b1;
        end else begin
            tapc_tdo    <= 1'b0;
            tapc_tdo_en <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // External chain interface
    // ------------------------------------------------------------------
    assign tap_state_o  = r_state;
    assign dr_sel_o     = w_sel;
    assign dr_capture_o = (r_state == TAP_DR_CAPTURE) & (|w_sel);
    assign dr_shift_o   = (r_state == TAP_DR_SHIFT)   & (|w_sel);
    assign dr_update_o  = (r_state == TAP_DR_UPDATE)  & (|w_sel);
    assign dr_tdi_o     = tapc_tdi;

endmodule
`default_nettype wire

// File: tb/tb_scr1_tapc_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scr1_tapc_fsm
//  Description : Directed self-checking bench for scr1_tapc_fsm. A second
//                instance built with SCU_EN=0 shares all inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scr1_tapc_fsm;

    localparam logic [31:0] c_idcode = 32'hDEB11001;
    localparam logic [31:0] c_bld_id = 32'h5A3C_96E1;

    localparam logic [3:0] S_RESET    = 4'd0;
    localparam logic [3:0] S_IDLE     = 4'd1;
    localparam logic [3:0] S_DR_EXIT1 = 4'd5;
    localparam logic [3:0] S_DR_PAUSE = 4'd6;
    localparam logic [3:0] S_IR_SEL   = 4'd9;
    localparam logic [3:0] S_IR_SHIFT = 4'd11;

    logic       tck = 1'b0;
    logic       trst_n = 1'b1;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic [2:0] dr_tdo_i = 3'b000;

    logic       tdo, tdo_en, cap, sh, upd, dtdi;
    logic [3:0] state;
    logic [2:0] sel;
    logic       tdo_n, tdo_en_n, cap_n, sh_n, upd_n, dtdi_n;
    logic [3:0] state_n;
    logic [2:0] sel_n;

    int checks = 0;
    int failures = 0;

    scr1_tapc_fsm #(.IDCODE_VALUE(c_idcode), .BLD_ID_VALUE(c_bld_id), .SCU_EN(1'b1)) dut (
        .tapc_tck(tck), .tapc_trst_n(trst_n), .tapc_tms(tms), .tapc_tdi(tdi),
        .tapc_tdo(tdo), .tapc_tdo_en(tdo_en), .tap_state_o(state),
        .dr_sel_o(sel), .dr_capture_o(cap), .dr_shift_o(sh), .dr_update_o(upd),
        .dr_tdi_o(dtdi), .dr_tdo_i(dr_tdo_i)
    );

    scr1_tapc_fsm #(.IDCODE_VALUE(c_idcode), .BLD_ID_VALUE(c_bld_id), .SCU_EN(1'b0)) dut_noscu (
        .tapc_tck(tck), .tapc_trst_n(trst_n), .tapc_tms(tms), .tapc_tdi(tdi),
        .tapc_tdo(tdo_n), .tapc_tdo_en(tdo_en_n), .tap_state_o(state_n),
        .dr_sel_o(sel_n), .dr_capture_o(cap_n), .dr_shift_o(sh_n), .dr_update_o(upd_n),
        .dr_tdi_o(dtdi_n), .dr_tdo_i(dr_tdo_i)
    );

    always #10 tck = ~tck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One TCK cycle: inputs applied before the rising edge, outputs observed
    // just after the following falling edge.
    task automatic tick(input logic t_tms, input logic t_tdi);
        tms = t_tms;
        tdi = t_tdi;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // IDLE -> load IR with code -> IDLE
    task automatic load_ir(input logic [4:0] code);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(i == 4, code[i]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // IDLE -> Capture-DR -> Shift-DR
    task automatic goto_dr_shift();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // IDLE -> 32-bit DR scan -> IDLE, returning the TDO bits LSB first
    task automatic read_dr32(output logic [31:0] v);
        goto_dr_shift();
        for (int i = 0; i < 32; i++) begin
            v[i] = tdo;
            tick(i == 31, 1'b0);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        trst_n = 1'b1;
        #1 trst_n = 1'b0;
        repeat (2) @(negedge tck);
        #1;
        checks++; if (state !== S_RESET) begin failures++; $display("FAIL reset_state: got %0d expected %0d", state, S_RESET); end
        checks++; if (tdo !== 1'b0 || tdo_en !== 1'b0) begin failures++; $display("FAIL reset_tdo: got tdo=%b en=%b expected 0 0", tdo, tdo_en); end
        checks++; if ({sel, cap, sh, upd} !== 6'd0) begin failures++; $display("FAIL reset_dr_if: got %b expected 000000", {sel, cap, sh, upd}); end
        trst_n = 1'b1;
        tick(1'b1, 1'b0);
        checks++; if (state !== S_RESET) begin failures++; $display("FAIL reset_hold_tms1: got %0d expected %0d", state, S_RESET); end
        tick(1'b0, 1'b0);
        checks++; if (state !== S_IDLE) begin failures++; $display("FAIL reset_to_idle: got %0d expected %0d", state, S_IDLE); end
    endtask

    task automatic test_idcode();
        logic [31:0] w;
        int en_bad;
        en_bad = 0;
        checks++; if (tdo_en !== 1'b0) begin failures++; $display("FAIL idcode_en_idle: got %b expected 0", tdo_en); end
        goto_dr_shift();
        for (int i = 0; i < 32; i++) begin
            w[i] = tdo;
            if (tdo_en !== 1'b1) en_bad++;
            tick(i == 31, 1'b0);
        end
        checks++; if (w !== c_idcode) begin failures++; $display("FAIL idcode_value: got %h expected %h", w, c_idcode); end
        checks++; if (en_bad != 0) begin failures++; $display("FAIL idcode_en_shift: got %0d low cycles expected 0", en_bad); end
        checks++; if (state !== S_DR_EXIT1 || tdo_en !== 1'b0) begin failures++; $display("FAIL idcode_exit: got state=%0d en=%b expected 5 0", state, tdo_en); end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_bld_id();
        logic [31:0] w;
        load_ir(5'h04);
        read_dr32(w);
        checks++; if (w !== c_bld_id) begin failures++; $display("FAIL bld_id_value: got %h expected %h", w, c_bld_id); end
    endtask

    task automatic test_bypass();
        logic [3:0] tdi_seq;
        logic [3:0] obs;
        tdi_seq = 4'b1101;
        load_ir(5'h1F);
        checks++; if (sel !== 3'b000) begin failures++; $display("FAIL bypass_sel: got %b expected 000", sel); end
        goto_dr_shift();
        for (int k = 0; k < 4; k++) begin
            obs[k] = tdo;
            tick(k == 3, tdi_seq[k]);
        end
        checks++; if (obs !== 4'b1010) begin failures++; $display("FAIL bypass_tdo: got %b expected 1010", obs); end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_dmi();
        logic [40:0] pat;
        logic [40:0] obs;
        int sh_cnt, cap_bad, tdi_bad;
        pat = 41'h1A5C3F09E6B;
        sh_cnt = 0; cap_bad = 0; tdi_bad = 0;
        load_ir(5'h11);
        checks++; if (sel !== 3'b010 || cap !== 1'b0) begin failures++; $display("FAIL dmi_sel_idle: got sel=%b cap=%b expected 010 0", sel, cap); end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        checks++; if (cap !== 1'b1 || sh !== 1'b0) begin failures++; $display("FAIL dmi_capture: got cap=%b sh=%b expected 1 0", cap, sh); end
        dr_tdo_i = {~pat[0], pat[0], ~pat[0]};
        tick(1'b0, 1'b0);
        for (int i = 0; i <= 40; i++) begin
            obs[i] = tdo;
            if (sh === 1'b1) sh_cnt++;
            if (cap !== 1'b0) cap_bad++;
            if (i < 40) dr_tdo_i = {~pat[i+1], pat[i+1], ~pat[i+1]};
            tick(i == 40, i[0]);
            if (dtdi !== tdi) tdi_bad++;
        end
        checks++; if (obs !== pat) begin failures++; $display("FAIL dmi_tdo: got %h expected %h", obs, pat); end
        checks++; if (sh_cnt != 41 || cap_bad != 0) begin failures++; $display("FAIL dmi_strobes: got shift=%0d cap_bad=%0d expected 41 0", sh_cnt, cap_bad); end
        checks++; if (tdi_bad != 0) begin failures++; $display("FAIL dmi_tdi_pass: got %0d mismatches expected 0", tdi_bad); end
        checks++; if (sh !== 1'b0) begin failures++; $display("FAIL dmi_shift_exit: got %b expected 0", sh); end
        tick(1'b1, 1'b0);
        checks++; if (upd !== 1'b1) begin failures++; $display("FAIL dmi_update: got %b expected 1", upd); end
        tick(1'b0, 1'b0);
        checks++; if (upd !== 1'b0) begin failures++; $display("FAIL dmi_update_end: got %b expected 0", upd); end
        // Capture straight to Update with no Shift cycles
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        checks++; if (upd !== 1'b1 || sh !== 1'b0) begin failures++; $display("FAIL dmi_noshift_update: got upd=%b sh=%b expected 1 0", upd, sh); end
        tick(1'b0, 1'b0);
        dr_tdo_i = 3'b000;
    endtask

    task automatic test_ir_capture();
        logic [4:0] code;
        logic [4:0] obs;
        logic [1:0] obs2;
        code = 5'h0A;
        load_ir(code);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        checks++; if (state !== S_IR_SHIFT || tdo_en !== 1'b1) begin failures++; $display("FAIL ir_shift_entry: got state=%0d en=%b expected 11 1", state, tdo_en); end
        for (int k = 0; k < 5; k++) begin
            obs[k] = tdo;
            tick(k == 4, code[k]);
        end
        checks++; if (obs !== 5'b00001) begin failures++; $display("FAIL ir_capture_tdo: got %b expected 00001", obs); end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        checks++; if (sel !== 3'b000) begin failures++; $display("FAIL ir_0a_sel: got %b expected 000", sel); end
        goto_dr_shift();
        for (int k = 0; k < 2; k++) begin
            obs2[k] = tdo;
            tick(k == 1, k == 0);
        end
        checks++; if (obs2 !== 2'b10) begin failures++; $display("FAIL ir_0a_bypass: got %b expected 10", obs2); end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_scu_disable();
        load_ir(5'h09);
        checks++; if (sel !== 3'b100 || sel_n !== 3'b000) begin failures++; $display("FAIL scu_sel: got %b/%b expected 100/000", sel, sel_n); end
        dr_tdo_i = 3'b111;
        goto_dr_shift();
        checks++; if (tdo_n !== 1'b0 || tdo !== 1'b1) begin failures++; $display("FAIL scu_first_bit: got noscu=%b scu=%b expected 0 1", tdo_n, tdo); end
        tick(1'b0, 1'b1);
        checks++; if (tdo_n !== 1'b1 || sh_n !== 1'b0) begin failures++; $display("FAIL scu_off_bypass: got tdo=%b sh=%b expected 1 0", tdo_n, sh_n); end
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        dr_tdo_i = 3'b000;
    endtask

    task automatic test_pause_resume();
        logic [31:0] w;
        load_ir(5'h01);
        goto_dr_shift();
        for (int i = 0; i < 32; i++) begin
            w[i] = tdo;
            if (i == 7) begin
                tick(1'b1, 1'b0);
                tick(1'b0, 1'b0);
                tick(1'b0, 1'b0);
                checks++; if (state !== S_DR_PAUSE || tdo_en !== 1'b0) begin failures++; $display("FAIL pause_state: got state=%0d en=%b expected 6 0", state, tdo_en); end
                tick(1'b1, 1'b0);
                tick(1'b0, 1'b0);
            end else begin
                tick(i == 31, 1'b0);
            end
        end
        checks++; if (w !== c_idcode) begin failures++; $display("FAIL pause_resume: got %h expected %h", w, c_idcode); end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_trst_mid_shift();
        logic [31:0] w;
        load_ir(5'h11);
        goto_dr_shift();
        checks++; if (sh !== 1'b1 || sel !== 3'b010) begin failures++; $display("FAIL trst_pre: got sh=%b sel=%b expected 1 010", sh, sel); end
        #3 trst_n = 1'b0;
        #1;
        checks++; if (state !== S_RESET || tdo_en !== 1'b0 || tdo !== 1'b0) begin failures++; $display("FAIL trst_async: got state=%0d en=%b tdo=%b expected 0 0 0", state, tdo_en, tdo); end
        checks++; if ({sel, cap, sh, upd} !== 6'd0) begin failures++; $display("FAIL trst_dr_if: got %b expected 000000", {sel, cap, sh, upd}); end
        @(negedge tck);
        #1;
        trst_n = 1'b1;
        tick(1'b0, 1'b0);
        checks++; if (state !== S_IDLE) begin failures++; $display("FAIL trst_release: got %0d expected %0d", state, S_IDLE); end
        read_dr32(w);
        checks++; if (w !== c_idcode) begin failures++; $display("FAIL trst_ir_idcode: got %h expected %h", w, c_idcode); end
    endtask

    task automatic test_tlr();
        logic [31:0] w;
        load_ir(5'h11);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        checks++; if (state !== S_DR_PAUSE) begin failures++; $display("FAIL tlr_pause: got %0d expected %0d", state, S_DR_PAUSE); end
        repeat (4) tick(1'b1, 1'b0);
        checks++; if (state !== S_IR_SEL || sel !== 3'b010) begin failures++; $display("FAIL tlr_four: got state=%0d sel=%b expected 9 010", state, sel); end
        tick(1'b1, 1'b0);
        checks++; if (state !== S_RESET || sel !== 3'b000) begin failures++; $display("FAIL tlr_five: got state=%0d sel=%b expected 0 000", state, sel); end
        tick(1'b0, 1'b0);
        read_dr32(w);
        checks++; if (w !== c_idcode) begin failures++; $display("FAIL tlr_ir_idcode: got %h expected %h", w, c_idcode); end
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_bld_id();
        test_bypass();
        test_dmi();
        test_ir_capture();
        test_scu_disable();
        test_pause_resume();
        test_trst_mid_shift();
        test_tlr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
